soc_data_bus: RTL
=================

Name: soc_data_bus

Overview:
- Data-side bus controller between the pipeline CPU data port and the data memory system.
- Replaces the direct CPU-to-RAM wiring with a parametrised, stallable controller:
  - decodes each CPU access to one of: the data RAM, one of N_PER peripheral channels, or unmapped space;
  - holds the CPU with a stall while the access completes;
  - returns read data plus an error flag.
- RAM read latency is configurable; peripherals use a sel/ack handshake.

Parameters:
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- ADDR_W, 32, CPU byte-address width.
- RAM_AW, 10, RAM word-address width; the RAM region is 4*2^RAM_AW bytes.
- RAM_BASE, 0, byte base address of the RAM region.
- RAM_LAT, 1, RAM read latency in cycles (>=1) from ram_en to valid ram_rdata.
- N_PER, 4, number of peripheral channels (1..8).
- PER_BASE, 32'hF000_0000, base address of peripheral channel 0.
- PER_AW, 8, byte-offset width per channel; channel i occupies PER_BASE + i*2^PER_AW.
- TIMEOUT, 16, peripheral ack timeout in cycles (used only with SOC_BUS_TIMEOUT_EN).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- cpu_req, in, 1: access request; CPU holds it and its qualifiers until cpu_ready.
- cpu_we, in, 1: 1 = write.
- cpu_be, in, DATA_W/8: byte enables.
- cpu_addr, in, ADDR_W: byte address.
- cpu_wdata, in, DATA_W: write data.
- cpu_rdata, out, DATA_W: read data, valid while cpu_ready=1.
- cpu_ready, out, 1: one-cycle completion pulse.
- cpu_err, out, 1: error qualifier of cpu_ready.
- cpu_stall, out, 1: pipeline freeze.
- ram_en, out, 1: RAM access strobe.
- ram_we, out, DATA_W/8: RAM byte write strobes.
- ram_addr, out, RAM_AW: RAM word address (addr[RAM_AW+1:2] of the offset).
- ram_wdata, out, DATA_W: RAM write data.
- ram_rdata, in, DATA_W: RAM read data.
- per_sel, out, N_PER: one-hot peripheral select.
- per_we, out, 1: peripheral write.
- per_be, out, DATA_W/8: peripheral byte enables.
- per_addr, out, PER_AW: byte offset within the channel.
- per_wdata, out, DATA_W: peripheral write data.
- per_rdata, in, N_PER*DATA_W: channel i occupies slice [i*DATA_W +: DATA_W].
- per_ack, in, N_PER: per-channel acknowledge.

Behaviour:
- Reset (rst=0, async, also mid-transaction):
  - FSM goes to IDLE.
  - All outputs are 0, including cpu_rdata; ram_en and per_sel drop immediately.
  - The in-flight access is abandoned; no cpu_ready is issued.
- FSM states: IDLE, RAM_ACC, RAM_WAIT, PER_WAIT, RESP.
- IDLE:
  - cpu_stall = cpu_req (combinational).
  - When cpu_req=1, latch we/be/addr/wdata and decode:
    - RAM hit → RAM_ACC;
    - channel i hit → PER_WAIT;
    - unmapped → RESP with err=1, rdata=0; writes are dropped.
- RAM_ACC (1 cycle):
  - ram_en=1; ram_we = be if write, else 0.
  - Write → RESP.
  - Read → RAM_WAIT, with the counter loaded to RAM_LAT-1.
- RAM_WAIT:
  - Counts down.
  - At 0, captures ram_rdata into the rdata register → RESP.
- PER_WAIT:
  - per_sel[i]=1, with per_we/be/addr/wdata held stable.
  - Only per_ack[i] is honoured; ack in the first sel cycle is accepted.
  - On ack, capture slice i → RESP.
- RESP (1 cycle):
  - cpu_ready=1, cpu_err as set, cpu_stall=0.
  - Always → IDLE, so there is one bubble between back-to-back accesses.
- cpu_stall=1 in RAM_ACC, RAM_WAIT and PER_WAIT.
- Latency, with the request sampled in cycle N:
  - RAM write: ready at N+2.
  - RAM read: ready at N+2+RAM_LAT.
  - Peripheral: ready in the cycle after the ack cycle.
  - Unmapped: ready at N+1.
- cpu_rdata holds its value outside RESP; it is 0 after a write or error response.
- Decode precedence when regions overlap: RAM > lowest-index peripheral.
- Addresses wrap modulo 2^ADDR_W in range compares; there is no carry into the decode.

Optional Feature:
- Macro: SOC_BUS_TIMEOUT_EN.
- Defined:
  - PER_WAIT counts cycles with no ack.
  - After TIMEOUT cycles → RESP with err=1 and rdata=0; per_sel drops.
  - A late ack is ignored.
- Undefined: PER_WAIT waits indefinitely, and no counter is synthesised.

Decomposition:
- Package soc_bus_pkg holds:
  - the FSM state enum;
  - the region enum (REG_RAM, REG_PER, REG_NONE);
  - the constant ERR_RDATA=0;
  - localparam helpers for per_rdata slice indexing.
- Sub-module soc_bus_decoder:
  - combinational;
  - input cpu_addr; outputs region, channel index, RAM word address and per_addr;
  - parametrised identically to soc_data_bus.

Test Plan:
- Reset: rst=0 mid RAM_WAIT → cpu_ready/ram_en/cpu_stall all 0 immediately; after release, FSM is IDLE and the next access works.
- RAM write then read, RAM_LAT=1:
  - write addr 0x10, data 0xA5A5_1234, be=4'hF → ram_we=4'hF, ram_addr=4, ready at N+2.
  - read same addr → cpu_rdata=0xA5A5_1234, ready at N+3.
- Byte write: be=4'b0010 at addr 0x10 → ram_we=4'b0010; subsequent read returns 0xA5A5_XX34, where XX is the written byte.
- Peripheral channel 2 read at 0xF000_0204:
  - per_sel=4'b0100 and per_addr=0x04;
  - ack after 3 cycles with slice data 0x0000_BEEF → cpu_rdata=0x0000_BEEF, err=0, stall high for 4 cycles.
- Unmapped read at 0x8000_0000 → cpu_ready at N+1, cpu_err=1, cpu_rdata=0, no ram_en or per_sel.
- SOC_BUS_TIMEOUT_EN, TIMEOUT=16: channel 0 never acks → ready with err=1 exactly 16 cycles into PER_WAIT; per_sel clears; ack on cycle 20 is ignored.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared types and helpers for the SoC data-side bus controller.
package soc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM_ACC,
    S_RAM_WAIT,
    S_PER_WAIT,
    S_RESP
  } bus_state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_PER,
    REG_NONE
  } region_t;

  localparam int ERR_RDATA = 0;

  // A single channel still needs a 1-bit index so the select logic stays uniform.
  function automatic int chan_w(input int n_per);
    return (n_per > 1) ? $clog2(n_per) : 1;
  endfunction

  function automatic int slice_lo(input int chan, input int data_w);
    return chan * data_w;
  endfunction

endpackage

// File: rtl/soc_bus_decoder.sv
// Combinational address decoder: classifies a CPU byte address as RAM,
// a peripheral channel or unmapped space, and extracts the local offsets.
module soc_bus_decoder
  import soc_bus_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 32,
  parameter int              RAM_AW   = 10,
  parameter logic [ADDR_W-1:0] RAM_BASE = '0,
  parameter int              RAM_LAT  = 1,
  parameter int              N_PER    = 4,
  parameter logic [ADDR_W-1:0] PER_BASE = 'hF000_0000,
  parameter int              PER_AW   = 8,
  parameter int              TIMEOUT  = 16
) (
  input  logic [ADDR_W-1:0]        cpu_addr,
  output region_t                  region,
  output logic [chan_w(N_PER)-1:0] chan,
  output logic [RAM_AW-1:0]        ram_addr,
  output logic [PER_AW-1:0]        per_addr
);

  localparam int CH_W = chan_w(N_PER);

  logic [ADDR_W-1:0] w_ramOff;
  logic [ADDR_W-1:0] w_perOff;
  logic [ADDR_W-1:0] w_perChan;

  // Offsets wrap modulo 2^ADDR_W, so an address below a base lands far out of range.
  assign w_ramOff  = cpu_addr - RAM_BASE;
  assign w_perOff  = cpu_addr - PER_BASE;
  assign w_perChan = w_perOff >> PER_AW;

  always_comb begin
    region = REG_NONE;
    if ((w_ramOff >> (RAM_AW + 2)) == '0) begin
      region = REG_RAM;
    end else if (w_perChan < ADDR_W'(N_PER)) begin
      region = REG_PER;
    end
  end

  assign chan     = w_perChan[CH_W-1:0];
  assign ram_addr = w_ramOff[RAM_AW+1:2];
  assign per_addr = w_perOff[PER_AW-1:0];

endmodule

// File: rtl/soc_data_bus.sv
// Stallable data-side bus controller between the CPU data port, the data RAM
// and N_PER peripheral channels. Define SOC_BUS_TIMEOUT_EN for the ack timeout.
module soc_data_bus
  import soc_bus_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 32,
  parameter int              RAM_AW   = 10,
  parameter logic [ADDR_W-1:0] RAM_BASE = '0,
  parameter int              RAM_LAT  = 1,
  parameter int              N_PER    = 4,
  parameter logic [ADDR_W-1:0] PER_BASE = 'hF000_0000,
  parameter int              PER_AW   = 8,
  parameter int              TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [DATA_W/8-1:0]     cpu_be,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_err,
  output logic                    cpu_stall,
  output logic                    ram_en,
  output logic [DATA_W/8-1:0]     ram_we,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic [N_PER-1:0]        per_sel,
  output logic                    per_we,
  output logic [DATA_W/8-1:0]     per_be,
  output logic [PER_AW-1:0]       per_addr,
  output logic [DATA_W-1:0]       per_wdata,
  input  logic [N_PER*DATA_W-1:0] per_rdata,
  input  logic [N_PER-1:0]        per_ack
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CH_W  = chan_w(N_PER);
  localparam int LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  bus_state_t          r_state;
  bus_state_t          w_stateNext;
  logic                r_we;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [RAM_AW-1:0]   r_ramAddr;
  logic [PER_AW-1:0]   r_perAddr;
  logic [CH_W-1:0]     r_ch;
  logic                r_err;
  logic [LAT_W-1:0]    r_latCnt;

  region_t             w_region;
  logic [CH_W-1:0]     w_ch;
  logic [RAM_AW-1:0]   w_ramAddr;
  logic [PER_AW-1:0]   w_perAddr;
  logic                w_ack;
  logic [DATA_W-1:0]   w_perRdata;
  logic                w_timeout;

  soc_bus_decoder #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RAM_AW  (RAM_AW),
    .RAM_BASE(RAM_BASE),
    .RAM_LAT (RAM_LAT),
    .N_PER   (N_PER),
    .PER_BASE(PER_BASE),
    .PER_AW  (PER_AW),
    .TIMEOUT (TIMEOUT)
  ) u_decoder (
    .cpu_addr(cpu_addr),
    .region  (w_region),
    .chan    (w_ch),
    .ram_addr(w_ramAddr),
    .per_addr(w_perAddr)
  );

  // Only the latched channel's ack and data are visible; the others are ignored.
  always_comb begin
    w_ack      = 1'b0;
    w_perRdata = '0;
    per_sel    = '0;
    for (int i = 0; i < N_PER; i++) begin
      if (r_ch == CH_W'(i)) begin
        w_ack      = per_ack[i];
        w_perRdata = per_rdata[slice_lo(i, DATA_W) +: DATA_W];
        per_sel[i] = (r_state == S_PER_WAIT);
      end
    end
  end

`ifdef SOC_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_toCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_toCnt <= '0;
    end else if (r_state != S_PER_WAIT) begin
      r_toCnt <= '0;
    end else begin
      r_toCnt <= r_toCnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_PER_WAIT) && !w_ack && (r_toCnt == TO_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Stall is gated by reset so every output reads 0 while rst is low.
  always_comb begin
    w_stateNext = r_state;
    cpu_ready   = 1'b0;
    cpu_err     = 1'b0;
    cpu_stall   = 1'b0;
    ram_en      = 1'b0;
    ram_we      = '0;
    case (r_state)
      S_IDLE: begin
        cpu_stall = cpu_req & rst;
        if (cpu_req) begin
          case (w_region)
            REG_RAM: w_stateNext = S_RAM_ACC;
            REG_PER: w_stateNext = S_PER_WAIT;
            default: w_stateNext = S_RESP;
          endcase
        end
      end
      S_RAM_ACC: begin
        cpu_stall   = 1'b1;
        ram_en      = 1'b1;
        ram_we      = r_we ? r_be : '0;
        w_stateNext = r_we ? S_RESP : S_RAM_WAIT;
      end
      S_RAM_WAIT: begin
        cpu_stall = 1'b1;
        if (r_latCnt == '0) begin
          w_stateNext = S_RESP;
        end
      end
      S_PER_WAIT: begin
        cpu_stall = 1'b1;
        if (w_ack || w_timeout) begin
          w_stateNext = S_RESP;
        end
      end
      S_RESP: begin
        cpu_ready   = 1'b1;
        cpu_err     = r_err;
        w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // r_rdata only changes on the edge entering RESP, so it holds between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we      <= 1'b0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_ramAddr <= '0;
      r_perAddr <= '0;
      r_ch      <= '0;
      r_err     <= 1'b0;
      r_latCnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_we      <= cpu_we;
            r_be      <= cpu_be;
            r_wdata   <= cpu_wdata;
            r_ramAddr <= w_ramAddr;
            r_perAddr <= w_perAddr;
            r_ch      <= w_ch;
            r_err     <= (w_region == REG_NONE);
            if (w_region == REG_NONE) begin
              r_rdata <= DATA_W'(ERR_RDATA);
            end
          end
        end
        S_RAM_ACC: begin
          r_latCnt <= LAT_W'(RAM_LAT - 1);
          if (r_we) begin
            r_rdata <= '0;
          end
        end
        S_RAM_WAIT: begin
          if (r_latCnt == '0) begin
            r_rdata <= ram_rdata;
          end else begin
            r_latCnt <= r_latCnt - 1'b1;
          end
        end
        S_PER_WAIT: begin
          if (w_ack) begin
            r_rdata <= r_we ? '0 : w_perRdata;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= DATA_W'(ERR_RDATA);
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign ram_addr  = r_ramAddr;
  assign ram_wdata = r_wdata;
  assign per_we    = r_we;
  assign per_be    = r_be;
  assign per_addr  = r_perAddr;
  assign per_wdata = r_wdata;

endmodule
